// File: rtl/fib_call_stack.sv
`default_nettype none
// ============================================================================
// Module      : fib_call_stack
// Description : LIFO frame storage for the recursive Fibonacci datapath.
//               Each push writes one word, chosen by pushSrc from the return
//               flag, n or the partial result. The top of stack is presented
//               combinationally so the controller can pop it in the same cycle.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk      in   1      system clock, rising edge
//   rstN     in   1      synchronous active-low reset
//   push     in   1      write selected source onto stack
//   pop      in   1      remove top entry (push+pop = replace top)
//   pushSrc  in   2      0: flagIn, 1: nIn, 2: resIn, 3: constant 0
//   flagIn   in   1      return flag, zero-extended on push
//   nIn      in   WIDTH  current n
//   resIn    in   WIDTH  current partial result
//   popData  out  WIDTH  top entry, 0 when empty
//   count    out  CNT_W  number of valid entries
//   empty    out  1      count == 0
//   full     out  1      count == DEPTH
//   ovfErr   out  1      sticky: push attempted while full
//   udfErr   out  1      sticky: pop attempted while empty
//   maxDepth out  CNT_W  high-water mark (only with FIB_STACK_HWM_EN)
// Configuration
//   FIB_STACK_HWM_EN : when defined, adds the maxDepth high-water mark.
// ============================================================================
module fib_call_stack #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rstN,
   input  logic             push,
   input  logic             pop,
   input  logic [1:0]       pushSrc,
   input  logic             flagIn,
   input  logic [WIDTH-1:0] nIn,
   input  logic [WIDTH-1:0] resIn,
   output logic [WIDTH-1:0] popData,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full,
   output logic             ovfErr,
`ifdef FIB_STACK_HWM_EN
   output logic             udfErr,
   output logic [CNT_W-1:0] maxDepth
`else
   output logic             udfErr
`endif
);

   localparam int               ADDR_W  = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

   logic [WIDTH-1:0]  r_mem [DEPTH];
   logic [CNT_W-1:0]  r_count;
   logic              r_ovf;
   logic              r_udf;

   logic [CNT_W-1:0]  w_count_nxt;
   logic              w_ovf_set;
   logic              w_udf_set;
   logic              w_wr_en;
   logic [ADDR_W-1:0] w_wr_addr;
   logic [ADDR_W-1:0] w_top_addr;
   logic [WIDTH-1:0]  w_src;
   logic              w_empty;
   logic              w_full;

   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == C_DEPTH);
   // Only meaningful when not empty; popData masks the empty case.
   assign w_top_addr = ADDR_W'(r_count - CNT_W'(1));

   assign popData = w_empty ? '0 : r_mem[w_top_addr];
   assign count   = r_count;
   assign empty   = w_empty;
   assign full    = w_full;
   assign ovfErr  = r_ovf;
   assign udfErr  = r_udf;

   // Source select
   always_comb begin
      w_src = '0;
      case (pushSrc)
         2'd0:    w_src = WIDTH'(flagIn);
         2'd1:    w_src = nIn;
         2'd2:    w_src = resIn;
         default: w_src = '0;
      endcase
   end

   // Next-state decode. Writes are only ever issued to a legal address:
   // a plain push targets count (< DEPTH when not full), a replace targets
   // the current top.
   always_comb begin
      w_count_nxt = r_count;
      w_wr_en     = 1'b0;
      w_wr_addr   = '0;
      w_ovf_set   = 1'b0;
      w_udf_set   = 1'b0;
      case ({push, pop})
         2'b10: begin
            if (w_full) begin
               w_ovf_set = 1'b1;
            end else begin
               w_wr_en     = 1'b1;
               w_wr_addr   = ADDR_W'(r_count);
               w_count_nxt = r_count + CNT_W'(1);
            end
         end
         2'b01: begin
            if (w_empty) begin
               w_udf_set = 1'b1;
            end else begin
               w_count_nxt = r_count - CNT_W'(1);
            end
         end
         2'b11: begin
            w_wr_en = 1'b1;
            if (w_empty) begin
               // Nothing to replace: behaves as a push, but the pop half
               // is still an underflow.
               w_wr_addr   = '0;
               w_count_nxt = CNT_W'(1);
               w_udf_set   = 1'b1;
            end else begin
               w_wr_addr = w_top_addr;
            end
         end
         default: ;
      endcase
   end

   // Frame storage is never cleared; reset only suppresses the write.
   always_ff @(posedge clk) begin
      if (rstN && w_wr_en) begin
         r_mem[w_wr_addr] <= w_src;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         r_count <= '0;
         r_ovf   <= 1'b0;
         r_udf   <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         r_ovf   <= r_ovf | w_ovf_set;
         r_udf   <= r_udf | w_udf_set;
      end
   end

`ifdef FIB_STACK_HWM_EN
   logic [CNT_W-1:0] r_max;

   assign maxDepth = r_max;

   always_ff @(posedge clk) begin
      if (!rstN) begin
         r_max <= '0;
      end else if (w_count_nxt > r_max) begin
         r_max <= w_count_nxt;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fib_call_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_fib_call_stack
// Description : Self-checking bench for fib_call_stack. A queue-based LIFO
//               model tracks the expected stack contents and error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fib_call_stack;

   localparam int WIDTH = 16;
   localparam int DEPTH = 32;
   localparam int CNT_W = 6;

   logic             clk = 1'b0;
   logic             rstN;
   logic             push;
   logic             pop;
   logic [1:0]       pushSrc;
   logic             flagIn;
   logic [WIDTH-1:0] nIn;
   logic [WIDTH-1:0] resIn;
   logic [WIDTH-1:0] popData;
   logic [CNT_W-1:0] count;
   logic             empty;
   logic             full;
   logic             ovfErr;
   logic             udfErr;
`ifdef FIB_STACK_HWM_EN
   logic [CNT_W-1:0] maxDepth;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // Reference model
   logic [WIDTH-1:0] m_q[$];
   logic             m_ovf;
   logic             m_udf;
   int               m_hwm;

   fib_call_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk     (clk),
      .rstN    (rstN),
      .push    (push),
      .pop     (pop),
      .pushSrc (pushSrc),
      .flagIn  (flagIn),
      .nIn     (nIn),
      .resIn   (resIn),
      .popData (popData),
      .count   (count),
      .empty   (empty),
      .full    (full),
      .ovfErr  (ovfErr),
`ifdef FIB_STACK_HWM_EN
      .udfErr  (udfErr),
      .maxDepth(maxDepth)
`else
      .udfErr  (udfErr)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [WIDTH-1:0] src_value(input logic [1:0] s, input logic f,
                                                  input logic [WIDTH-1:0] n,
                                                  input logic [WIDTH-1:0] r);
      case (s)
         2'd0:    return (f ? 16'd1 : 16'd0);
         2'd1:    return n;
         2'd2:    return r;
         default: return 16'd0;
      endcase
   endfunction

   function automatic logic [WIDTH-1:0] m_top();
      if (m_q.size() == 0) return '0;
      return m_q[m_q.size()-1];
   endfunction

   // Clocks one edge with the currently driven inputs and advances the model.
   task automatic tick();
      logic [WIDTH-1:0] v;
      v = src_value(pushSrc, flagIn, nIn, resIn);
      @(posedge clk);
      #1;
      if (!rstN) begin
         m_q.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
         m_hwm = 0;
      end else begin
         if (push && !pop) begin
            if (m_q.size() == DEPTH) m_ovf = 1'b1;
            else m_q.push_back(v);
         end else if (!push && pop) begin
            if (m_q.size() == 0) m_udf = 1'b1;
            else void'(m_q.pop_back());
         end else if (push && pop) begin
            if (m_q.size() == 0) begin
               m_q.push_back(v);
               m_udf = 1'b1;
            end else begin
               m_q[m_q.size()-1] = v;
            end
         end
         if (m_q.size() > m_hwm) m_hwm = m_q.size();
      end
      push = 1'b0;
      pop  = 1'b0;
   endtask

   task automatic do_push(input logic [1:0] s, input logic f, input logic [WIDTH-1:0] n,
                          input logic [WIDTH-1:0] r);
      push = 1'b1; pop = 1'b0; pushSrc = s; flagIn = f; nIn = n; resIn = r;
      tick();
   endtask

   task automatic do_reset();
      rstN = 1'b0;
      tick();
      rstN = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (count !== 0 || empty !== 1'b1 || full !== 1'b0 || popData !== 16'd0 ||
          ovfErr !== 1'b0 || udfErr !== 1'b0) begin
         n_errors++;
         $display("FAIL reset: count=%0d empty=%b full=%b popData=%h ovf=%b udf=%b, required 0 1 0 0000 0 0",
                  count, empty, full, popData, ovfErr, udfErr);
      end
   endtask

   task automatic test_frame();
      logic [WIDTH-1:0] exp_pop [3];
      exp_pop[0] = 16'd1; exp_pop[1] = 16'd8; exp_pop[2] = 16'd5;
      do_reset();
      do_push(2'd1, 1'b0, 16'd5, 16'd0);
      do_push(2'd2, 1'b0, 16'd0, 16'd8);
      do_push(2'd0, 1'b1, 16'hFFFF, 16'hFFFF);
      n_checks++;
      if (count !== 3 || popData !== 16'd1) begin
         n_errors++;
         $display("FAIL frame_push: count=%0d popData=%h, required 3 0001", count, popData);
      end
      for (int i = 0; i < 3; i++) begin
         pop = 1'b1;
         #1;
         n_checks++;
         if (popData !== exp_pop[i]) begin
            n_errors++;
            $display("FAIL frame_pop%0d: popData=%h, required %h", i, popData, exp_pop[i]);
         end
         tick();
      end
      n_checks++;
      if (empty !== 1'b1 || popData !== 16'd0) begin
         n_errors++;
         $display("FAIL frame_empty: empty=%b popData=%h, required 1 0000", empty, popData);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < DEPTH; i++) do_push(2'd1, 1'b0, 16'(i), 16'd0);
      n_checks++;
      if (full !== 1'b1 || ovfErr !== 1'b0 || count !== DEPTH) begin
         n_errors++;
         $display("FAIL fill: full=%b ovf=%b count=%0d, required 1 0 %0d", full, ovfErr, count, DEPTH);
      end
      do_push(2'd2, 1'b0, 16'd0, 16'hBEEF);
      n_checks++;
      if (full !== 1'b1 || count !== 32 || ovfErr !== 1'b1 || popData !== 16'd31) begin
         n_errors++;
         $display("FAIL overflow: full=%b count=%0d ovf=%b popData=%h, required 1 32 1 001f",
                  full, count, ovfErr, popData);
      end
      // Replace while full is legal and leaves count alone.
      push = 1'b1; pop = 1'b1; pushSrc = 2'd2; resIn = 16'h1234;
      tick();
      n_checks++;
      if (count !== 32 || popData !== 16'h1234 || udfErr !== 1'b0) begin
         n_errors++;
         $display("FAIL full_replace: count=%0d popData=%h udf=%b, required 32 1234 0", count, popData, udfErr);
      end
   endtask

   task automatic test_underflow();
      do_reset();
      pop = 1'b1;
      #1;
      n_checks++;
      if (popData !== 16'd0) begin
         n_errors++;
         $display("FAIL udf_popdata: popData=%h, required 0000", popData);
      end
      tick();
      n_checks++;
      if (udfErr !== 1'b1 || count !== 0) begin
         n_errors++;
         $display("FAIL underflow: udf=%b count=%0d, required 1 0", udfErr, count);
      end
      do_push(2'd1, 1'b0, 16'd7, 16'd0);
      n_checks++;
      if (count !== 1 || popData !== 16'd7 || udfErr !== 1'b1 || ovfErr !== 1'b0) begin
         n_errors++;
         $display("FAIL udf_sticky: count=%0d popData=%h udf=%b ovf=%b, required 1 0007 1 0",
                  count, popData, udfErr, ovfErr);
      end
   endtask

   task automatic test_replace();
      do_reset();
      do_push(2'd1, 1'b0, 16'd3, 16'd0);
      do_push(2'd1, 1'b0, 16'd9, 16'd0);
      push = 1'b1; pop = 1'b1; pushSrc = 2'd2; resIn = 16'd4;
      tick();
      n_checks++;
      if (count !== 2 || popData !== 16'd4 || udfErr !== 1'b0) begin
         n_errors++;
         $display("FAIL replace: count=%0d popData=%h udf=%b, required 2 0004 0", count, popData, udfErr);
      end
      pop = 1'b1;
      tick();
      n_checks++;
      if (popData !== 16'd3) begin
         n_errors++;
         $display("FAIL replace_below: popData=%h, required 0003", popData);
      end
      do_reset();
      push = 1'b1; pop = 1'b1; pushSrc = 2'd1; nIn = 16'd2;
      tick();
      n_checks++;
      if (count !== 1 || udfErr !== 1'b1 || popData !== 16'd2) begin
         n_errors++;
         $display("FAIL replace_empty: count=%0d udf=%b popData=%h, required 1 1 0002", count, udfErr, popData);
      end
      // Constant-zero source.
      do_push(2'd3, 1'b1, 16'hAAAA, 16'h5555);
      n_checks++;
      if (count !== 2 || popData !== 16'd0) begin
         n_errors++;
         $display("FAIL src_zero: count=%0d popData=%h, required 2 0000", count, popData);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      pop = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) do_push(2'd1, 1'b0, 16'(16'h100 + i), 16'd0);
      rstN = 1'b0; push = 1'b1; pushSrc = 2'd1; nIn = 16'hDEAD;
      tick();
      rstN = 1'b1;
      n_checks++;
      if (count !== 0 || ovfErr !== 1'b0 || udfErr !== 1'b0 || empty !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_mid: count=%0d ovf=%b udf=%b empty=%b, required 0 0 0 1",
                  count, ovfErr, udfErr, empty);
      end
      do_push(2'd2, 1'b0, 16'd0, 16'h0055);
      n_checks++;
      if (count !== 1 || popData !== 16'h0055) begin
         n_errors++;
         $display("FAIL reset_next_push: count=%0d popData=%h, required 1 0055", count, popData);
      end
   endtask

   task automatic test_random();
      int r;
      do_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         r = $urandom_range(0, 99);
         rstN    = (r >= 2);
         // Alternating phases bias towards filling and draining.
         if ((cyc / 80) % 2 == 0) begin
            push = ($urandom_range(0, 99) < 70);
            pop  = ($urandom_range(0, 99) < 35);
         end else begin
            push = ($urandom_range(0, 99) < 35);
            pop  = ($urandom_range(0, 99) < 70);
         end
         pushSrc = 2'($urandom_range(0, 3));
         flagIn  = 1'($urandom);
         nIn     = 16'($urandom);
         resIn   = 16'($urandom);
         #1;
         n_checks++;
         if (rstN && pop && popData !== m_top()) begin
            n_errors++;
            $display("FAIL rand_pop_cyc%0d: popData=%h, required %h", cyc, popData, m_top());
         end
         tick();
         rstN = 1'b1;
         n_checks++;
         if (count !== CNT_W'(m_q.size()) || popData !== m_top() ||
             empty !== (m_q.size() == 0) || full !== (m_q.size() == DEPTH) ||
             ovfErr !== m_ovf || udfErr !== m_udf) begin
            n_errors++;
            $display("FAIL rand_cyc%0d: count=%0d popData=%h empty=%b full=%b ovf=%b udf=%b, required %0d %h %b %b %b %b",
                     cyc, count, popData, empty, full, ovfErr, udfErr, m_q.size(), m_top(),
                     (m_q.size() == 0), (m_q.size() == DEPTH), m_ovf, m_udf);
         end
`ifdef FIB_STACK_HWM_EN
         n_checks++;
         if (maxDepth !== CNT_W'(m_hwm)) begin
            n_errors++;
            $display("FAIL rand_hwm_cyc%0d: maxDepth=%0d, required %0d", cyc, maxDepth, m_hwm);
         end
`endif
      end
   endtask

`ifdef FIB_STACK_HWM_EN
   task automatic test_hwm();
      do_reset();
      for (int i = 0; i < 4; i++) do_push(2'd1, 1'b0, 16'(i), 16'd0);
      pop = 1'b1; tick();
      pop = 1'b1; tick();
      do_push(2'd1, 1'b0, 16'd9, 16'd0);
      n_checks++;
      if (maxDepth !== 4 || count !== 3) begin
         n_errors++;
         $display("FAIL hwm: maxDepth=%0d count=%0d, required 4 3", maxDepth, count);
      end
      do_reset();
      n_checks++;
      if (maxDepth !== 0) begin
         n_errors++;
         $display("FAIL hwm_reset: maxDepth=%0d, required 0", maxDepth);
      end
   endtask
`endif

   initial begin
      rstN = 1'b0; push = 1'b0; pop = 1'b0; pushSrc = 2'd0;
      flagIn = 1'b0; nIn = '0; resIn = '0;
      m_ovf = 1'b0; m_udf = 1'b0; m_hwm = 0;
      @(posedge clk);
      #1;
      test_reset();
      test_frame();
      test_overflow();
      test_underflow();
      test_replace();
      test_reset_mid();
`ifdef FIB_STACK_HWM_EN
      test_hwm();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
